// File: rtl/mem_pkg.sv
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and helpers for the banked simple-dual-port RAM
//                and its clear sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  // Clear sequencer states: IDLE serves external traffic, CLEAR sweeps memory.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } mem_clr_state_t;

  localparam int c_MAX_OUTPUT_DELAY = 2;

  // Legal read latencies are 0 (async), 1 and 2 register stages.
  function automatic bit output_delay_ok(input int od);
    return (od >= 0) && (od <= c_MAX_OUTPUT_DELAY);
  endfunction

  // Banks are laid out back to back in one flat storage array.
  function automatic int unsigned flat_addr(input int unsigned bank,
                                            input int unsigned addr,
                                            input int unsigned depth);
    return bank * depth + addr;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_clear_sequencer.sv
// ============================================================================
//  Module      : mem_clear_sequencer
//  Description : Sweeps every flat word address once, emitting a write strobe
//                per cycle, after reset or on a clr pulse. A clr during a
//                sweep restarts it from address 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_clear_sequencer
  import mem_pkg::*;
#(
  parameter int unsigned WORDS  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(WORDS - 1);

  mem_clr_state_t    state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;

  // Sweep FSM: reset parks in CLEAR at address 0 so a full sweep follows release.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr) begin
            cnt_q <= '0;
          end else if (cnt_q == c_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = cnt_q;

endmodule

`default_nettype wire

// File: rtl/mem_multi_bank.sv
// ============================================================================
//  Module      : mem_multi_bank
//  Description : Banked simple-dual-port RAM with selectable read latency
//                (0/1/2), optional write-first bypass and a built-in clear
//                sweep to DEFAULT_VALUE.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_multi_bank
  import mem_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    DEPTH         = 16,
  parameter int                    NUM_BANKS     = 2,
  parameter int                    OUTPUT_DELAY  = 1,
  parameter int                    BYPASS        = 0,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             clr,
  output logic                                             busy,
  input  logic                                             wea,
  input  logic [((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1)-1:0] bank_a,
  input  logic [$clog2(DEPTH)-1:0]                         addra,
  input  logic [DATA_WIDTH-1:0]                            dia,
  input  logic                                             reb,
  input  logic [((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1)-1:0] bank_b,
  input  logic [$clog2(DEPTH)-1:0]                         addrb,
  output logic [DATA_WIDTH-1:0]                            dob,
  output logic                                             dob_valid
);

  localparam int c_BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_WORDS  = NUM_BANKS * DEPTH;
  localparam int c_FLAT_W = $clog2(c_WORDS);

  if (!output_delay_ok(OUTPUT_DELAY)) begin : g_bad_output_delay
    $error("mem_multi_bank: OUTPUT_DELAY must be 0, 1 or 2");
  end

  // With a single bank the select bit carries no information.
  function automatic logic [c_FLAT_W-1:0] to_flat(input logic [c_BANK_W-1:0] bank,
                                                  input logic [c_ADDR_W-1:0] addr);
    int unsigned b;
    b = (NUM_BANKS > 1) ? 32'(bank) : 32'd0;
    return c_FLAT_W'(flat_addr(b, 32'(addr), DEPTH));
  endfunction

  logic                  w_busy;
  logic                  w_clr_we;
  logic [c_FLAT_W-1:0]   w_clr_addr;
  logic [c_FLAT_W-1:0]   w_flat_a;
  logic [c_FLAT_W-1:0]   w_flat_b;
  logic                  w_ext_we;
  logic                  w_wr_en;
  logic [c_FLAT_W-1:0]   w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic                  w_collide;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [DATA_WIDTH-1:0] mem_q [c_WORDS];

  mem_clear_sequencer #(
    .WORDS  (c_WORDS),
    .ADDR_W (c_FLAT_W)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .busy     (w_busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  assign busy      = w_busy;
  assign w_flat_a  = to_flat(bank_a, addra);
  assign w_flat_b  = to_flat(bank_b, addrb);

  // The sweep owns the write port while busy; external writes are dropped then.
  assign w_ext_we  = wea & ~w_busy;
  assign w_wr_en   = w_busy ? w_clr_we : w_ext_we;
  assign w_wr_addr = w_busy ? w_clr_addr : w_flat_a;
  assign w_wr_data = w_busy ? DEFAULT_VALUE : dia;

  // Storage: one write per cycle, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[w_wr_addr] <= w_wr_data;
    end
  end

  // Read data before the output stages: the array itself yields old data on a
  // collision, so only write-first needs an explicit forward of dia.
  assign w_collide = w_ext_we && (w_flat_a == w_flat_b);
  assign w_rd_data = w_busy                      ? DEFAULT_VALUE :
                     ((BYPASS != 0) && w_collide) ? dia           :
                                                    mem_q[w_flat_b];

  if (OUTPUT_DELAY == 0) begin : g_async
    logic w_unused_reb;
    assign w_unused_reb = reb;
    assign dob          = w_rd_data;
    assign dob_valid    = 1'b1;
  end else begin : g_sync
    logic [DATA_WIDTH-1:0] dob1_q;
    logic                  val1_q;

    // First read stage: captures on reb, holds otherwise.
    always_ff @(posedge clk) begin
      if (reset) begin
        dob1_q <= DEFAULT_VALUE;
        val1_q <= 1'b0;
      end else begin
        val1_q <= reb;
        if (reb) begin
          dob1_q <= w_rd_data;
        end
      end
    end

    if (OUTPUT_DELAY == 1) begin : g_one
      assign dob       = dob1_q;
      assign dob_valid = val1_q;
    end else begin : g_two
      logic [DATA_WIDTH-1:0] dob2_q;
      logic                  val2_q;

      // Second stage advances every cycle, refreshing data only behind a valid.
      always_ff @(posedge clk) begin
        if (reset) begin
          dob2_q <= DEFAULT_VALUE;
          val2_q <= 1'b0;
        end else begin
          val2_q <= val1_q;
          if (val1_q) begin
            dob2_q <= dob1_q;
          end
        end
      end

      assign dob       = dob2_q;
      assign dob_valid = val2_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_multi_bank.sv
// ============================================================================
//  Module      : tb_mem_multi_bank
//  Description : Self-checking bench for mem_multi_bank. Five instances share
//                one stimulus stream and cover latency 0/1/2 with read-old and
//                write-first collision behaviour against a word-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_multi_bank;

  localparam int         c_NB    = 4;
  localparam int         c_DEPTH = 16;
  localparam int         c_DW    = 8;
  localparam int         c_WORDS = c_NB * c_DEPTH;
  localparam int         c_NDUT  = 5;
  localparam logic [7:0] c_DEF   = 8'h5A;
  localparam int         c_OD  [c_NDUT] = '{1, 1, 2, 0, 0};
  localparam int         c_BYP [c_NDUT] = '{0, 1, 1, 0, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       clr   = 1'b0;
  logic       wea   = 1'b0;
  logic       reb   = 1'b0;
  logic [1:0] bank_a = '0;
  logic [1:0] bank_b = '0;
  logic [3:0] addra  = '0;
  logic [3:0] addrb  = '0;
  logic [7:0] dia    = '0;

  logic       busy_w [c_NDUT];
  logic [7:0] dob_w  [c_NDUT];
  logic       val_w  [c_NDUT];

  for (genvar g = 0; g < c_NDUT; g++) begin : g_dut
    mem_multi_bank #(
      .DATA_WIDTH    (c_DW),
      .DEPTH         (c_DEPTH),
      .NUM_BANKS     (c_NB),
      .OUTPUT_DELAY  (c_OD[g]),
      .BYPASS        (c_BYP[g]),
      .DEFAULT_VALUE (c_DEF)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .clr       (clr),
      .busy      (busy_w[g]),
      .wea       (wea),
      .bank_a    (bank_a),
      .addra     (addra),
      .dia       (dia),
      .reb       (reb),
      .bank_b    (bank_b),
      .addrb     (addrb),
      .dob       (dob_w[g]),
      .dob_valid (val_w[g])
    );
  end

  // Reference model: word array, remaining sweep cycles, per-instance pipeline.
  logic [7:0] m_mem [c_WORDS];
  int         m_left  = 0;
  bit         m_busy  = 1'b1;
  bit         m_ready = 1'b0;
  logic [7:0] m_d1 [c_NDUT];
  logic [7:0] m_d2 [c_NDUT];
  bit         m_v1 [c_NDUT];
  bit         m_v2 [c_NDUT];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Value a read issued this cycle returns, from the behavioural rules.
  function automatic logic [7:0] read_val(input int k);
    int fa;
    int fb;
    fa = int'(bank_a) * c_DEPTH + int'(addra);
    fb = int'(bank_b) * c_DEPTH + int'(addrb);
    if (m_busy) return c_DEF;
    if (c_BYP[k] == 1 && wea && fa == fb) return dia;
    return m_mem[fb];
  endfunction

  task automatic model_edge();
    logic [7:0] rv;
    int         fa;
    for (int k = 0; k < c_NDUT; k++) begin
      if (c_OD[k] == 0) continue;
      rv = read_val(k);
      if (reset) begin
        m_d1[k] = c_DEF; m_v1[k] = 1'b0;
        m_d2[k] = c_DEF; m_v2[k] = 1'b0;
      end else begin
        m_v2[k] = m_v1[k];
        if (m_v1[k]) m_d2[k] = m_d1[k];
        m_v1[k] = reb;
        if (reb) m_d1[k] = rv;
      end
    end
    fa = int'(bank_a) * c_DEPTH + int'(addra);
    if (!reset && !m_busy && wea) m_mem[fa] = dia;
    // A sweep hides memory behind DEFAULT reads, so clearing the whole array
    // at its start is observably the same as clearing word by word.
    if (reset || clr) begin
      m_left = c_WORDS;
      for (int i = 0; i < c_WORDS; i++) m_mem[i] = c_DEF;
    end else if (m_left > 0) begin
      m_left--;
    end
    m_busy = (m_left > 0);
  endtask

  task automatic comb_checks();
    for (int k = 0; k < c_NDUT; k++) begin
      if (c_OD[k] != 0) continue;
      check($sformatf("dut%0d_dob_async", k), dob_w[k], read_val(k));
      check($sformatf("dut%0d_valid_async", k), val_w[k], 1'b1);
    end
  endtask

  task automatic reg_checks();
    for (int k = 0; k < c_NDUT; k++) begin
      check($sformatf("dut%0d_busy", k), busy_w[k], m_busy);
      if (c_OD[k] == 1) begin
        check($sformatf("dut%0d_dob", k), dob_w[k], m_d1[k]);
        check($sformatf("dut%0d_valid", k), val_w[k], m_v1[k]);
      end else if (c_OD[k] == 2) begin
        check($sformatf("dut%0d_dob", k), dob_w[k], m_d2[k]);
        check($sformatf("dut%0d_valid", k), val_w[k], m_v2[k]);
      end
    end
  endtask

  // One clock: async outputs checked mid-cycle, registered ones just after the edge.
  task automatic cycle();
    @(negedge clk);
    if (m_ready) comb_checks();
    @(posedge clk);
    model_edge();
    m_ready = 1'b1;
    #1;
    reg_checks();
  endtask

  // Counts busy cycles; sweep cycle index n may carry a dropped write or a restart.
  task automatic sweep_count(input int restart_at, input int write_at, output int n);
    n = 0;
    while (busy_w[0] === 1'b1 && n < 400) begin
      wea = 1'b0;
      clr = 1'b0;
      if (n == write_at) begin
        wea = 1'b1; bank_a = 2'd1; addra = 4'd0; dia = 8'hFF;
      end
      if (n == restart_at) clr = 1'b1;
      n++;
      cycle();
    end
    wea = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset for 3 cycles with a read request pending: no valid may appear.
    reb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      for (int k = 0; k < 3; k++) begin
        check($sformatf("rst_valid%0d", k), val_w[k], 1'b0);
        check($sformatf("rst_dob%0d", k), dob_w[k], c_DEF);
      end
      check("rst_busy", busy_w[0], 1'b1);
    end
    reset = 1'b0;
    reb   = 1'b0;
    sweep_count(-1, -1, n);
    check("init_sweep_len", n, 64);

    // Cleared word in the last bank.
    reb = 1'b1; bank_b = 2'd3; addrb = 4'd15;
    cycle();
    check("rd_b3a15_dob", dob_w[0], 8'h5A);
    check("rd_b3a15_valid", val_w[0], 1'b1);
    reb = 1'b0;
    cycle();

    // Write then read back with 1- and 2-cycle latency.
    wea = 1'b1; bank_a = 2'd2; addra = 4'd7; dia = 8'hC3;
    cycle();
    wea = 1'b0; reb = 1'b1; bank_b = 2'd2; addrb = 4'd7;
    cycle();
    check("lat1_b2a7", dob_w[0], 8'hC3);
    check("lat2_not_yet", val_w[2], 1'b0);
    bank_b = 2'd1;
    cycle();
    check("lat1_b1a7", dob_w[0], 8'h5A);
    check("lat2_b2a7", dob_w[2], 8'hC3);
    check("lat2_b2a7_valid", val_w[2], 1'b1);
    reb = 1'b0;
    cycle();
    check("lat2_b1a7", dob_w[2], 8'h5A);
    check("lat1_idle_valid", val_w[0], 1'b0);

    // Same-cycle write/read collision on bank 0 addr 3.
    wea = 1'b1; bank_a = 2'd0; addra = 4'd3; dia = 8'h22;
    cycle();
    dia = 8'h11; reb = 1'b1; bank_b = 2'd0; addrb = 4'd3;
    #1;
    check("coll_async_old", dob_w[3], 8'h22);
    check("coll_async_new", dob_w[4], 8'h11);
    cycle();
    check("coll_readold", dob_w[0], 8'h22);
    check("coll_writefirst", dob_w[1], 8'h11);
    wea = 1'b0;
    #1;
    check("after_async_old", dob_w[3], 8'h11);
    cycle();
    check("after_readold", dob_w[0], 8'h11);
    check("coll_lat2_writefirst", dob_w[2], 8'h11);
    reb = 1'b0;
    cycle();

    // Fill every word, then a clr sweep with a dropped write and a restart.
    for (int i = 0; i < c_WORDS; i++) begin
      wea = 1'b1; bank_a = 2'(i / 16); addra = 4'(i % 16); dia = 8'(i * 3 + 1);
      cycle();
    end
    wea = 1'b0;
    reb = 1'b1; bank_b = 2'd0; addrb = 4'd5;
    cycle();
    check("fill_b0a5", dob_w[0], 8'h10);
    reb = 1'b0;
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    sweep_count(29, 10, n);
    check("restart_sweep_len", n, 30 + 64);
    for (int i = 0; i < c_WORDS; i++) begin
      reb = 1'b1; bank_b = 2'(i / 16); addrb = 4'(i % 16);
      cycle();
      check($sformatf("cleared_w%0d", i), dob_w[0], c_DEF);
    end
    reb = 1'b0;
    cycle();

    // Randomized traffic with frequent collisions and occasional clr.
    for (int i = 0; i < 400; i++) begin
      wea    = ($urandom_range(0, 1) == 1);
      bank_a = 2'($urandom);
      addra  = 4'($urandom);
      dia    = 8'($urandom);
      reb    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        bank_b = bank_a; addrb = addra;
      end else begin
        bank_b = 2'($urandom); addrb = 4'($urandom);
      end
      clr = ($urandom_range(0, 199) == 0);
      cycle();
    end
    wea = 1'b0; clr = 1'b0; reb = 1'b0;
    for (int i = 0; i < 80; i++) cycle();

    // Reset in the middle of a sweep with reads in flight.
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      reb = 1'b1; bank_b = 2'($urandom); addrb = 4'($urandom);
      cycle();
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      for (int k = 0; k < 3; k++) begin
        check($sformatf("midrst_valid%0d", k), val_w[k], 1'b0);
        check($sformatf("midrst_dob%0d", k), dob_w[k], c_DEF);
      end
    end
    reset = 1'b0;
    reb   = 1'b0;
    sweep_count(-1, -1, n);
    check("post_rst_sweep_len", n, 64);
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
